// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute-stage ALU plus the EX/MEM pipeline register.
// A purely combinational ALU feeds the EX/MEM registers. The registers
// handle stall, flush and bubble loads. Write-back is suppressed when a
// signed add/sub overflows, and a saturating counter tracks committed
// overflow events.
module ex_alu_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       alu_conf,
  input  logic             sign,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       shamt,
  input  logic [4:0]       rd_in,
  input  logic             reg_write_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic [4:0]       rd_out,
  output logic             reg_write_out,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0011;
  localparam logic [3:0] C_SLT = 4'b0100;
  localparam logic [3:0] C_NOR = 4'b0101;
  localparam logic [3:0] C_XOR = 4'b0110;
  localparam logic [3:0] C_SLL = 4'b0111;
  localparam logic [3:0] C_SRL = 4'b1000;
  localparam logic [3:0] C_SRA = 4'b1001;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic             w_lt;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;
  logic             w_reg_write;

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;
  logic [4:0]       r_rd;
  logic             r_reg_write;
  logic [CNT_W-1:0] r_ovf_count;

  assign w_sum  = in_a + in_b;
  assign w_diff = in_a - in_b;

  // Two's-complement overflow from the operand and result sign bits.
  assign w_add_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
  assign w_sub_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
  assign w_lt      = sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);

  // ALU operation select. Unused codes yield zero with no overflow.
  always_comb begin
    w_result   = '0;
    w_overflow = 1'b0;
    case (alu_conf)
      C_AND: w_result = in_a & in_b;
      C_OR:  w_result = in_a | in_b;
      C_ADD: begin
        w_result   = w_sum;
        w_overflow = sign & w_add_ovf;
      end
      C_SUB: begin
        w_result   = w_diff;
        w_overflow = sign & w_sub_ovf;
      end
      C_SLT: w_result = {{(WIDTH-1){1'b0}}, w_lt};
      C_NOR: w_result = ~(in_a | in_b);
      C_XOR: w_result = in_a ^ in_b;
      C_SLL: w_result = in_b << shamt;
      C_SRL: w_result = in_b >> shamt;
      C_SRA: w_result = $unsigned($signed(in_b) >>> shamt);
      default: begin
        w_result   = '0;
        w_overflow = 1'b0;
      end
    endcase
  end

  // An overflowing instruction must not write back, but still flows downstream to trap.
  assign w_reg_write = reg_write_in & in_valid & ~w_overflow;

  // EX/MEM register. Priority is reset > flush > stall > load; an invalid load is a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
    end else if (flush || (!stall && !in_valid)) begin
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_overflow  <= 1'b0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
    end else if (!stall) begin
      r_valid     <= 1'b1;
      r_result    <= w_result;
      r_zero      <= (w_result == '0);
      r_overflow  <= w_overflow;
      r_rd        <= rd_in;
      r_reg_write <= w_reg_write;
    end
  end

  // Saturating count of overflow events that were actually loaded into EX/MEM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_count <= '0;
    end else if (!flush && !stall && in_valid && w_overflow &&
                 (r_ovf_count != {CNT_W{1'b1}})) begin
      r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

  assign out_valid     = r_valid;
  assign out_result    = r_result;
  assign out_zero      = r_zero;
  assign out_overflow  = r_overflow;
  assign rd_out        = r_rd;
  assign reg_write_out = r_reg_write;
  assign ovf_count     = r_ovf_count;

endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Execute-stage datapath of the pipelined MIPS core. It sits directly downstream of the ALU control decoder and consumes its 4-bit ALU configuration code and sign flag. It computes the ALU result on the ID/EX operands and captures it, together with write-back control, into the EX/MEM pipeline register, with stall, flush and signed-overflow suppression.

## Interface
- WIDTH, 32, datapath width; only 32 is supported.
- CNT_W, 8, width of the saturating overflow event counter.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  ID/EX holds a real instruction (0 = bubble)
- stall  in  1  hold EX/MEM contents this cycle
- flush  in  1  load a bubble into EX/MEM this cycle
- alu_conf  in  4  operation code from the ALU control decoder
- sign  in  1  1 = signed compare and overflow-checked add/sub
- in_a  in  WIDTH  operand A (rs)
- in_b  in  WIDTH  operand B (rt or immediate)
- shamt  in  5  shift amount
- rd_in  in  5  destination register
- reg_write_in  in  1  write-back enable
- out_valid  out  1  EX/MEM holds a real instruction
- out_result  out  WIDTH  registered ALU result
- out_zero  out  1  registered (result == 0)
- out_overflow  out  1  registered signed-overflow flag
- rd_out  out  5  registered destination register
- reg_write_out  out  1  registered write-back enable, after overflow suppression
- ovf_count  out  CNT_W  saturating count of committed overflow events

## Operation
- alu_conf decode:
  - 0000: A&B
  - 0001: A|B
  - 0010: A+B
  - 0011: A−B
  - 0100: SLT, signed compare when sign=1, unsigned when sign=0; result is 32'd1 or 32'd0
  - 0101: ~(A|B)
  - 0110: A^B
  - 0111: B<<shamt
  - 1000: B>>shamt (logical)
  - 1001: B>>>shamt (arithmetic)
  - 1010–1111: result 0, overflow 0
- Arithmetic is modulo 2^32. Shifts use shamt only, never in_a.
- Overflow is raised only for conf 0010/0011 with sign=1.
  - add: operands have the same sign and the result sign differs.
  - sub: operands have different signs and the result sign differs from A.
  - It is never raised when sign=0.
- Suppression: reg_write_next = reg_write_in & in_valid & ~overflow. An overflowing instruction still propagates out_valid=1 and out_overflow=1 so a later stage can trap.
- Register update priority: reset > flush > stall > load.
  - reset: all outputs go to 0, including ovf_count.
  - flush: out_valid, reg_write_out, out_overflow and rd_out go to 0; out_result goes to 0 and out_zero to 1 (bubble).
  - stall (no flush): all registers hold.
  - load: registers capture the computed values; out_valid = in_valid.
- When in_valid=0 on load, the bubble is loaded exactly as for flush.
- ovf_count increments on a load with in_valid=1 and overflow=1. It saturates at 2^CNT_W−1 and is unaffected by stall and flush.

## Timing
- One-cycle latency: operands presented in cycle N appear on the outputs after the clk edge ending cycle N.
- The ALU path from input to register D is purely combinational. There is no combinational path from inputs to outputs.
- Reset values: out_valid=0, out_result=0, out_zero=0, out_overflow=0, rd_out=0, reg_write_out=0, ovf_count=0.
- stall and flush asserted together: flush wins; the bubble is loaded.
- Reset asserted together with anything else: reset wins.
- Reset mid-stall: the stall is discarded and the outputs take their reset values on the next edge.
- Back-to-back loads with no stall: one result per cycle, no dead cycles.

## Test plan
- Reset, then ADD with A=5, B=7, sign=1, rd=3, reg_write=1 → next cycle: out_result=12, out_zero=0, rd_out=3, reg_write_out=1, out_valid=1.
- Signed ADD with A=0x7FFFFFFF, B=1 → out_result=0x80000000, out_overflow=1, reg_write_out=0, out_valid=1, ovf_count=1. The same operands with sign=0 → overflow=0, reg_write_out=1.
- SLT with A=0xFFFFFFFF, B=1: sign=1 → result 1; sign=0 → result 0. SUB with A=9, B=9 → out_zero=1.
- Shift cases with B=0x80000010, shamt=4:
  - SLL → 0x00000100
  - SRL → 0x08000001
  - SRA → 0xF8000001
  - in_a is varied to confirm it has no effect.
- Load result X, then hold stall=1 for 3 cycles while the inputs change → outputs stay X. Then stall=1 with flush=1 → bubble: out_valid=0, reg_write_out=0, out_zero=1.
- Present 260 overflowing signed adds → ovf_count saturates at 255. A reset during the following stall clears every output to 0 on the next edge.
